// File: rtl/reg_slave_bank.sv
// Register-bus slave: NUM_REGS general registers plus ID, write-count and error-count
// specials, with read data returned through an RD_LATENCY-deep pipeline.
module reg_slave_bank #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [15:0] RESET_VAL  = 16'h0000,
  parameter logic [15:0] ID_VAL     = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  localparam logic [AW-1:0] ADDR_ERR_CNT = 8'hFD;
  localparam logic [AW-1:0] ADDR_WR_CNT  = 8'hFE;
  localparam logic [AW-1:0] ADDR_ID      = 8'hFF;
  localparam logic [DW-1:0] UNMAPPED_VAL = 16'hBAD0;
  localparam logic [DW-1:0] CNT_MAX      = 16'hFFFF;

  logic [DW-1:0] r_regs [NUM_REGS];
  logic [DW-1:0] r_pipe [RD_LATENCY];
  logic [DW-1:0] r_wr_cnt;
  logic [DW-1:0] r_err_cnt;

  logic [DW-1:0] w_rdata;
  logic          w_is_gen;
  logic          w_unmapped;
  logic          w_wr_inc;
  logic          w_err_inc;
  logic          w_err_clr;

  // Read mux sees pre-write state, giving read-before-write on collisions
  always_comb begin
    w_rdata    = UNMAPPED_VAL;
    w_is_gen   = 1'b0;
    w_unmapped = 1'b1;
    if (address == ADDR_ERR_CNT) begin
      w_rdata    = r_err_cnt;
      w_unmapped = 1'b0;
    end else if (address == ADDR_WR_CNT) begin
      w_rdata    = r_wr_cnt;
      w_unmapped = 1'b0;
    end else if (address == ADDR_ID) begin
      w_rdata    = ID_VAL;
      w_unmapped = 1'b0;
    end
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (address == AW'(i)) begin
        w_rdata    = r_regs[i];
        w_is_gen   = 1'b1;
        w_unmapped = 1'b0;
      end
    end
  end

  // One error per cycle at most: unmapped access or a write to a read-only special
  always_comb begin
    w_wr_inc  = write && (w_is_gen || (address == ADDR_ERR_CNT));
    w_err_clr = write && (address == ADDR_ERR_CNT);
    w_err_inc = w_unmapped || (write && ((address == ADDR_WR_CNT) || (address == ADDR_ID)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (write && (address == AW'(i))) r_regs[i] <= data_in;
      end
    end
  end

  // Saturating counters; a clear beats a simultaneous error increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_wr_inc && (r_wr_cnt != CNT_MAX)) r_wr_cnt <= r_wr_cnt + DW'(1);
      if (w_err_clr) begin
        r_err_cnt <= '0;
      end else if (w_err_inc && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < RD_LATENCY; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= w_rdata;
      for (int unsigned k = 1; k < RD_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign data_out = r_pipe[RD_LATENCY-1];

endmodule
